// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: ALU op codes, base opcodes and the ID/EX entry layout.
// Used by rv32i_decode_stage; the optional forwarding macro is RV32I_DECODE_FWD_EN (see top).
package rv32i_pkg;

  localparam int XLEN    = 32;
  localparam int ALU_OPW = 6;

  localparam logic [ALU_OPW-1:0] ALU_NONE = 6'd0;
  localparam logic [ALU_OPW-1:0] ALU_ADD  = 6'd1;
  localparam logic [ALU_OPW-1:0] ALU_SUB  = 6'd2;
  localparam logic [ALU_OPW-1:0] ALU_SLT  = 6'd3;
  localparam logic [ALU_OPW-1:0] ALU_SLTU = 6'd4;
  localparam logic [ALU_OPW-1:0] ALU_BEQ  = 6'd5;
  localparam logic [ALU_OPW-1:0] ALU_BNE  = 6'd6;
  localparam logic [ALU_OPW-1:0] ALU_BLT  = 6'd7;
  localparam logic [ALU_OPW-1:0] ALU_BGE  = 6'd8;
  localparam logic [ALU_OPW-1:0] ALU_BLTU = 6'd9;
  localparam logic [ALU_OPW-1:0] ALU_BGEU = 6'd10;
  localparam logic [ALU_OPW-1:0] ALU_AND  = 6'd11;
  localparam logic [ALU_OPW-1:0] ALU_OR   = 6'd12;
  localparam logic [ALU_OPW-1:0] ALU_XOR  = 6'd13;
  localparam logic [ALU_OPW-1:0] ALU_SLL  = 6'd14;
  localparam logic [ALU_OPW-1:0] ALU_SRL  = 6'd15;
  localparam logic [ALU_OPW-1:0] ALU_SRA  = 6'd16;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic [XLEN-1:0]    a;
    logic [XLEN-1:0]    b;
    logic [ALU_OPW-1:0] op;
    logic [XLEN-1:0]    imm;
    logic [XLEN-1:0]    pc;
    logic [4:0]         rd;
    logic               rdWe;
    logic               memRd;
    logic               memWr;
    logic [2:0]         funct3;
    logic               illegal;
  } decEntry_t;

  // subSel picks sub over add, sraSel picks sra over srl
  function automatic logic [ALU_OPW-1:0] arithOp(input logic [2:0] f3,
                                                 input logic subSel,
                                                 input logic sraSel);
    logic [ALU_OPW-1:0] op;
    op = ALU_NONE;
    case (f3)
      3'b000:  op = subSel ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = sraSel ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv32i_decode_stage_if.sv
// Upstream/downstream handshake bundle of the decode stage; slave = the stage, master = its environment.
interface rv32i_decode_stage_if #(parameter int width = 32, parameter int opw = 6);

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [width-1:0] in_pc;
  logic [width-1:0] rs1_data;
  logic [width-1:0] rs2_data;
  logic             wb_we;
  logic [4:0]       wb_rd;
  logic [width-1:0] wb_data;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [width-1:0] out_a;
  logic [width-1:0] out_b;
  logic [opw-1:0]   out_op;
  logic [width-1:0] out_imm;
  logic [width-1:0] out_pc;
  logic [4:0]       out_rd;
  logic             out_rd_we;
  logic             out_mem_rd;
  logic             out_mem_wr;
  logic [2:0]       out_funct3;
  logic             out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, rs1_data, rs2_data,
           wb_we, wb_rd, wb_data, flush, out_ready,
    output in_ready, out_valid, out_a, out_b, out_op, out_imm, out_pc,
           out_rd, out_rd_we, out_mem_rd, out_mem_wr, out_funct3, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, rs1_data, rs2_data,
           wb_we, wb_rd, wb_data, flush, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_op, out_imm, out_pc,
           out_rd, out_rd_we, out_mem_rd, out_mem_wr, out_funct3, out_illegal
  );

endinterface

// File: rtl/rv32i_imm_gen.sv
// Combinational RV32I immediate generator; every format is sign-extended to 32 bits.
module rv32i_imm_gen (
  input  logic [31:0] instr,
  output logic [31:0] immI,
  output logic [31:0] immS,
  output logic [31:0] immB,
  output logic [31:0] immU,
  output logic [31:0] immJ
);

  // The opcode field carries no immediate bits in any format
  logic unusedOpcode;
  assign unusedOpcode = ^instr[6:0];

  assign immI = {{20{instr[31]}}, instr[31:20]};
  assign immS = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign immB = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign immU = {instr[31:12], 12'b0};
  assign immJ = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

endmodule

// File: rtl/rv32i_decode_stage.sv
// RV32I decode/issue stage feeding the execute ALU through a one-entry ID/EX register.
// Define RV32I_DECODE_FWD_EN to bypass the writeback port onto rs1/rs2 at acceptance.
module rv32i_decode_stage
  import rv32i_pkg::*;
#(
  parameter int width = 32,
  parameter int opw   = 6
) (
  input logic                 clk,
  input logic                 rst,
  rv32i_decode_stage_if.slave bus
);

  logic [31:0]      instr;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic             funct7Ok;
  logic [31:0]      immI, immS, immB, immU, immJ;
  logic [width-1:0] rs1Val, rs2Val;
  decEntry_t        dec;
  decEntry_t        entry_d, entry_q;
  logic             valid_d, valid_q;
  logic             accept;

  assign instr    = bus.in_instr;
  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7   = instr[31:25];
  assign funct7Ok = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);

  rv32i_imm_gen immGen (
    .instr (instr),
    .immI  (immI),
    .immS  (immS),
    .immB  (immB),
    .immU  (immU),
    .immJ  (immJ)
  );

`ifdef RV32I_DECODE_FWD_EN
  // Bypass only affects the value captured at acceptance, never a held entry
  always_comb begin
    rs1Val = bus.rs1_data;
    rs2Val = bus.rs2_data;
    if (bus.wb_we && (bus.wb_rd != 5'd0) && (bus.wb_rd == instr[19:15])) rs1Val = bus.wb_data;
    if (bus.wb_we && (bus.wb_rd != 5'd0) && (bus.wb_rd == instr[24:20])) rs2Val = bus.wb_data;
  end
`else
  logic unusedWb;
  assign unusedWb = ^{bus.wb_we, bus.wb_rd, bus.wb_data};
  assign rs1Val   = bus.rs1_data;
  assign rs2Val   = bus.rs2_data;
`endif

  always_comb begin
    dec        = '0;
    dec.pc     = bus.in_pc;
    dec.rd     = instr[11:7];
    dec.funct3 = funct3;
    case (opcode)
      OPC_LUI: begin
        dec.b = immU; dec.imm = immU; dec.op = ALU_ADD; dec.rdWe = 1'b1;
      end
      OPC_AUIPC: begin
        dec.a = bus.in_pc; dec.b = immU; dec.imm = immU; dec.op = ALU_ADD; dec.rdWe = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        dec.a    = bus.in_pc;
        dec.b    = 32'd4;
        dec.imm  = (opcode == OPC_JAL) ? immJ : immI;
        dec.op   = ALU_ADD;
        dec.rdWe = 1'b1;
      end
      OPC_BRANCH: begin
        dec.a = rs1Val; dec.b = rs2Val; dec.imm = immB;
        case (funct3)
          3'b000:  dec.op = ALU_BEQ;
          3'b001:  dec.op = ALU_BNE;
          3'b100:  dec.op = ALU_BLT;
          3'b101:  dec.op = ALU_BGE;
          3'b110:  dec.op = ALU_BLTU;
          3'b111:  dec.op = ALU_BGEU;
          default: dec.illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec.a = rs1Val; dec.b = immI; dec.imm = immI; dec.op = ALU_ADD;
        dec.memRd = 1'b1; dec.rdWe = 1'b1;
      end
      OPC_STORE: begin
        dec.a = rs1Val; dec.b = immS; dec.imm = immS; dec.op = ALU_ADD; dec.memWr = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.a    = rs1Val;
        dec.b    = immI;
        dec.imm  = immI;
        dec.op   = arithOp(funct3, 1'b0, funct7[5]);
        dec.rdWe = 1'b1;
        // Shift-immediates carry the shamt in the rs2 field and a funct7 qualifier
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          dec.b       = {27'b0, instr[24:20]};
          dec.illegal = !funct7Ok;
        end
      end
      OPC_OP: begin
        dec.a       = rs1Val;
        dec.b       = rs2Val;
        dec.op      = arithOp(funct3, funct7 == 7'b0100000, funct7[5]);
        dec.rdWe    = 1'b1;
        dec.illegal = !funct7Ok;
      end
      default: dec.illegal = 1'b1;
    endcase
    if (dec.illegal) begin
      dec.a     = '0;
      dec.b     = '0;
      dec.imm   = '0;
      dec.op    = ALU_NONE;
      dec.rdWe  = 1'b0;
      dec.memRd = 1'b0;
      dec.memWr = 1'b0;
    end
    if (dec.rd == 5'd0) dec.rdWe = 1'b0;
  end

  assign bus.in_ready = !valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready && !bus.flush;

  // Flush wins over acceptance; a consumed entry with nothing new behind it empties the stage
  always_comb begin
    valid_d = valid_q;
    entry_d = entry_q;
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      entry_d = dec;
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      entry_q <= '0;
    end else begin
      valid_q <= valid_d;
      entry_q <= entry_d;
    end
  end

  assign bus.out_valid   = valid_q;
  assign bus.out_a       = entry_q.a;
  assign bus.out_b       = entry_q.b;
  assign bus.out_op      = opw'(entry_q.op);
  assign bus.out_imm     = entry_q.imm;
  assign bus.out_pc      = entry_q.pc;
  assign bus.out_rd      = entry_q.rd;
  assign bus.out_rd_we   = entry_q.rdWe;
  assign bus.out_mem_rd  = entry_q.memRd;
  assign bus.out_mem_wr  = entry_q.memWr;
  assign bus.out_funct3  = entry_q.funct3;
  assign bus.out_illegal = entry_q.illegal;

endmodule

// File: tb/tb_rv32i_decode_stage.sv
// Directed testbench for rv32i_decode_stage with hand-decoded expected values.
// Forwarding expectations follow RV32I_DECODE_FWD_EN.
module tb_rv32i_decode_stage;

  logic clk;
  logic rst;
  int   checks;
  int   fails;

  rv32i_decode_stage_if #(.width(32), .opw(6)) bus ();

  rv32i_decode_stage #(.width(32), .opw(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs, then returns 1 time unit after the capturing edge
  task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc,
                               input logic [31:0] rs1, input logic [31:0] rs2,
                               input logic valid, input logic outReady, input logic fl);
    bus.in_instr  = instr;
    bus.in_pc     = pc;
    bus.rs1_data  = rs1;
    bus.rs2_data  = rs2;
    bus.in_valid  = valid;
    bus.out_ready = outReady;
    bus.flush     = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    rst    = 1'b1;
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0;
    bus.rs1_data = '0;   bus.rs2_data = '0; bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    bus.wb_we = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst_valid",   32'(bus.out_valid), 32'd0);
    checkOutput("rst_a",       bus.out_a, 32'd0);
    checkOutput("rst_b",       bus.out_b, 32'd0);
    checkOutput("rst_op",      32'(bus.out_op), 32'd0);
    checkOutput("rst_imm",     bus.out_imm, 32'd0);
    checkOutput("rst_pc",      bus.out_pc, 32'd0);
    checkOutput("rst_rd",      32'(bus.out_rd), 32'd0);
    checkOutput("rst_flags",   32'({bus.out_rd_we, bus.out_mem_rd, bus.out_mem_wr, bus.out_illegal}), 32'd0);
    checkOutput("rst_inready", 32'(bus.in_ready), 32'd1);

    // ADDI x1,x0,5
    applyStimulus(32'h00500093, 32'h100, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
    checkOutput("addi_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("addi_op",    32'(bus.out_op), 32'd1);
    checkOutput("addi_a",     bus.out_a, 32'd0);
    checkOutput("addi_b",     bus.out_b, 32'd5);
    checkOutput("addi_imm",   bus.out_imm, 32'd5);
    checkOutput("addi_rd",    32'(bus.out_rd), 32'd1);
    checkOutput("addi_rdwe",  32'(bus.out_rd_we), 32'd1);
    checkOutput("addi_pc",    bus.out_pc, 32'h100);

    // SUB x3,x1,x2 back-to-back with the consume
    applyStimulus(32'h402081B3, 32'h104, 32'd10, 32'd3, 1'b1, 1'b1, 1'b0);
    checkOutput("sub_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("sub_op",    32'(bus.out_op), 32'd2);
    checkOutput("sub_a",     bus.out_a, 32'd10);
    checkOutput("sub_b",     bus.out_b, 32'd3);
    checkOutput("sub_rd",    32'(bus.out_rd), 32'd3);

    // SRAI x5,x6,3
    applyStimulus(32'h40335293, 32'h108, 32'h80, 32'hDEAD, 1'b1, 1'b1, 1'b0);
    checkOutput("srai_op",  32'(bus.out_op), 32'd16);
    checkOutput("srai_a",   bus.out_a, 32'h80);
    checkOutput("srai_b",   bus.out_b, 32'd3);
    checkOutput("srai_ill", 32'(bus.out_illegal), 32'd0);

    // BEQ x1,x2,+8
    applyStimulus(32'h00208463, 32'h10C, 32'd7, 32'd9, 1'b1, 1'b1, 1'b0);
    checkOutput("beq_op",   32'(bus.out_op), 32'd5);
    checkOutput("beq_imm",  bus.out_imm, 32'd8);
    checkOutput("beq_rdwe", 32'(bus.out_rd_we), 32'd0);
    checkOutput("beq_ab",   {bus.out_a[15:0], bus.out_b[15:0]}, {16'd7, 16'd9});

    // LUI x7,0x12345
    applyStimulus(32'h123453B7, 32'h110, 32'hFFFF, 32'd0, 1'b1, 1'b1, 1'b0);
    checkOutput("lui_a", bus.out_a, 32'd0);
    checkOutput("lui_b", bus.out_b, 32'h12345000);

    // SW x2,-4(x1)
    applyStimulus(32'hFE20AE23, 32'h114, 32'h1000, 32'd1, 1'b1, 1'b1, 1'b0);
    checkOutput("sw_b",     bus.out_b, 32'hFFFFFFFC);
    checkOutput("sw_a",     bus.out_a, 32'h1000);
    checkOutput("sw_mem",   32'({bus.out_mem_rd, bus.out_mem_wr}), 32'd1);
    checkOutput("sw_rdwe",  32'(bus.out_rd_we), 32'd0);
    checkOutput("sw_funct3",32'(bus.out_funct3), 32'd2);

    // JAL x1,+16
    applyStimulus(32'h010000EF, 32'h200, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
    checkOutput("jal_a",   bus.out_a, 32'h200);
    checkOutput("jal_b",   bus.out_b, 32'd4);
    checkOutput("jal_imm", bus.out_imm, 32'd16);
    checkOutput("jal_op",  32'(bus.out_op), 32'd1);

    // ADDI x0,x0,0: write enable suppressed for x0
    applyStimulus(32'h00000013, 32'h204, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
    checkOutput("nop_op",   32'(bus.out_op), 32'd1);
    checkOutput("nop_rdwe", 32'(bus.out_rd_we), 32'd0);

    // Unknown opcode, branch funct3=010, OP with funct7=0000001
    applyStimulus(32'hFFFFFFFF, 32'h208, 32'd1, 32'd2, 1'b1, 1'b1, 1'b0);
    checkOutput("badopc_ill",  32'(bus.out_illegal), 32'd1);
    checkOutput("badopc_op",   32'(bus.out_op), 32'd0);
    checkOutput("badopc_rdwe", 32'(bus.out_rd_we), 32'd0);
    applyStimulus(32'h0020A463, 32'h20C, 32'd1, 32'd2, 1'b1, 1'b1, 1'b0);
    checkOutput("badbr_ill",   32'(bus.out_illegal), 32'd1);
    checkOutput("badbr_op",    32'(bus.out_op), 32'd0);
    applyStimulus(32'h022081B3, 32'h210, 32'd1, 32'd2, 1'b1, 1'b1, 1'b0);
    checkOutput("badf7_ill",   32'(bus.out_illegal), 32'd1);
    checkOutput("badf7_rdwe",  32'(bus.out_rd_we), 32'd0);

    // Consume with no new input empties the stage
    applyStimulus(32'h00500093, 32'h300, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("drain_valid", 32'(bus.out_valid), 32'd0);

    // Load ADDI, then stall 3 cycles while SUB is offered
    applyStimulus(32'h00500093, 32'h400, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("stall_load_valid", 32'(bus.out_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(32'h402081B3, 32'h404, 32'd10, 32'd3, 1'b1, 1'b0, 1'b0);
      checkOutput("stall_valid",   32'(bus.out_valid), 32'd1);
      checkOutput("stall_op",      32'(bus.out_op), 32'd1);
      checkOutput("stall_b",       bus.out_b, 32'd5);
      checkOutput("stall_pc",      bus.out_pc, 32'h400);
      checkOutput("stall_inready", 32'(bus.in_ready), 32'd0);
    end
    applyStimulus(32'h402081B3, 32'h404, 32'd10, 32'd3, 1'b1, 1'b0, 1'b1);
    checkOutput("flush_valid",   32'(bus.out_valid), 32'd0);
    checkOutput("flush_inready", 32'(bus.in_ready), 32'd1);

    // Flush with out_ready high also drops the input
    applyStimulus(32'h00500093, 32'h500, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
    applyStimulus(32'h402081B3, 32'h504, 32'd10, 32'd3, 1'b1, 1'b1, 1'b1);
    checkOutput("flush2_valid", 32'(bus.out_valid), 32'd0);

    // Reset during a stall discards the held entry
    applyStimulus(32'h123453B7, 32'h600, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("rststall_pre", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    applyStimulus(32'h123453B7, 32'h600, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    checkOutput("rststall_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rststall_b",     bus.out_b, 32'd0);
    checkOutput("rststall_pc",    bus.out_pc, 32'd0);

    // Writeback bypass onto rs1 of ADDI x2,x1,1
    bus.wb_we = 1'b1; bus.wb_rd = 5'd1; bus.wb_data = 32'h55;
    applyStimulus(32'h00108113, 32'h700, 32'h11, 32'd0, 1'b1, 1'b1, 1'b0);
`ifdef RV32I_DECODE_FWD_EN
    checkOutput("fwd_a", bus.out_a, 32'h55);
`else
    checkOutput("fwd_a", bus.out_a, 32'h11);
`endif
    checkOutput("fwd_b", bus.out_b, 32'd1);
    bus.wb_rd = 5'd0;
    applyStimulus(32'h00108113, 32'h704, 32'h11, 32'd0, 1'b1, 1'b1, 1'b0);
    checkOutput("fwd_x0_a", bus.out_a, 32'h11);
    bus.wb_we = 1'b0;

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
